// File: rtl/eth_tx_framer.sv
// eth_tx_framer
// Builds Ethernet II frames for the logic side of the RGMII MAC transmitter.
// A 14-byte header (destination MAC, source MAC, EtherType) is prepended to a
// byte-wide ready/valid payload stream. Short payloads are zero-padded to the
// minimum length, and a fixed inter-frame gap is enforced between frames. The
// MAC adds the preamble, SFD and FCS itself.
//
// Ports:
//   mac_tx_clk, mac_tx_reset          clock, synchronous active-high reset
//   cfg_dst_mac, cfg_src_mac,         header fields, latched when a frame starts;
//   cfg_ethertype                     the most significant byte is sent first
//   s_tdata/s_tvalid/s_tlast/s_tready payload stream in
//   mac_tx_data/valid/sof/eof         frame stream to the MAC (registered)
//   busy                              framer is not idle (registered)
//   err_underrun, err_oversize        one-cycle error pulses (registered)
//   frame_cnt                         frames emitted, including aborted ones
module eth_tx_framer #(
  parameter int MAX_PAYLOAD = 1500,
  parameter int MIN_PAYLOAD = 46,
  parameter int IFG_CYCLES  = 20
) (
  input  logic        mac_tx_clk,
  input  logic        mac_tx_reset,
  input  logic [47:0] cfg_dst_mac,
  input  logic [47:0] cfg_src_mac,
  input  logic [15:0] cfg_ethertype,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_valid,
  output logic        mac_tx_sof,
  output logic        mac_tx_eof,
  output logic        busy,
  output logic        err_underrun,
  output logic        err_oversize,
  output logic [15:0] frame_cnt
);

  localparam int PW = $clog2(MAX_PAYLOAD + 1);
  localparam int GW = $clog2(IFG_CYCLES + 1);
  localparam logic [PW-1:0] MAX_P    = PW'(MAX_PAYLOAD);
  localparam logic [PW-1:0] MIN_P    = PW'(MIN_PAYLOAD);
  localparam logic [GW-1:0] IFG_LAST = GW'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PAD, DROP, IFG} state_t;

  state_t        state, state_nxt;
  logic [111:0]  hdr, hdr_nxt;
  logic [111:0]  hdr_sh;
  logic [3:0]    hdr_idx, hdr_idx_nxt;
  logic [PW-1:0] pay_cnt, pay_cnt_nxt, pay_inc;
  logic [GW-1:0] ifg_cnt, ifg_cnt_nxt;
  logic [7:0]    data_nxt;
  logic          valid_nxt, sof_nxt, eof_nxt, under_nxt, over_nxt;

  assign s_tready = (state == PAYLOAD) || (state == DROP);
  assign pay_inc  = pay_cnt + PW'(1);
  // Current header byte always sits in the top byte after shifting.
  assign hdr_sh   = hdr << {hdr_idx, 3'b000};

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt   = state;
    hdr_nxt     = hdr;
    hdr_idx_nxt = hdr_idx;
    pay_cnt_nxt = pay_cnt;
    ifg_cnt_nxt = ifg_cnt;
    data_nxt    = 8'h00;
    valid_nxt   = 1'b0;
    sof_nxt     = 1'b0;
    eof_nxt     = 1'b0;
    under_nxt   = 1'b0;
    over_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (s_tvalid) begin
          // Header byte 0 comes straight from the inputs being latched now.
          hdr_nxt     = {cfg_dst_mac, cfg_src_mac, cfg_ethertype};
          data_nxt    = cfg_dst_mac[47:40];
          valid_nxt   = 1'b1;
          sof_nxt     = 1'b1;
          hdr_idx_nxt = 4'd1;
          pay_cnt_nxt = '0;
          state_nxt   = HDR;
        end
      end
      HDR: begin
        data_nxt  = hdr_sh[111:104];
        valid_nxt = 1'b1;
        if (hdr_idx == 4'd13) state_nxt = PAYLOAD;
        else                  hdr_idx_nxt = hdr_idx + 4'd1;
      end
      PAYLOAD: begin
        valid_nxt = 1'b1;
        if (s_tvalid) begin
          data_nxt    = s_tdata;
          pay_cnt_nxt = pay_inc;
          if (s_tlast) begin
            if (pay_inc >= MIN_P) begin
              eof_nxt     = 1'b1;
              ifg_cnt_nxt = '0;
              state_nxt   = IFG;
            end else begin
              state_nxt = PAD;
            end
          end else if (pay_inc == MAX_P) begin
            eof_nxt   = 1'b1;
            over_nxt  = 1'b1;
            state_nxt = DROP;
          end
        end else begin
          // Starved mid-frame: close the frame with a dummy byte and discard the rest.
          eof_nxt   = 1'b1;
          under_nxt = 1'b1;
          state_nxt = DROP;
        end
      end
      PAD: begin
        valid_nxt   = 1'b1;
        pay_cnt_nxt = pay_inc;
        if (pay_inc >= MIN_P) begin
          eof_nxt     = 1'b1;
          ifg_cnt_nxt = '0;
          state_nxt   = IFG;
        end
      end
      DROP: begin
        if (s_tvalid && s_tlast) begin
          ifg_cnt_nxt = '0;
          state_nxt   = IFG;
        end
      end
      IFG: begin
        // IFG_CYCLES edges here plus the IDLE edge give IFG_CYCLES idle output cycles.
        if (ifg_cnt == IFG_LAST) state_nxt = IDLE;
        else                     ifg_cnt_nxt = ifg_cnt + GW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge mac_tx_clk) begin
    if (mac_tx_reset) begin
      state        <= IDLE;
      hdr          <= '0;
      hdr_idx      <= '0;
      pay_cnt      <= '0;
      ifg_cnt      <= '0;
      mac_tx_data  <= 8'h00;
      mac_tx_valid <= 1'b0;
      mac_tx_sof   <= 1'b0;
      mac_tx_eof   <= 1'b0;
      busy         <= 1'b0;
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
      frame_cnt    <= 16'h0000;
    end else begin
      state        <= state_nxt;
      hdr          <= hdr_nxt;
      hdr_idx      <= hdr_idx_nxt;
      pay_cnt      <= pay_cnt_nxt;
      ifg_cnt      <= ifg_cnt_nxt;
      mac_tx_data  <= data_nxt;
      mac_tx_valid <= valid_nxt;
      mac_tx_sof   <= sof_nxt;
      mac_tx_eof   <= eof_nxt;
      busy         <= (state_nxt != IDLE);
      err_underrun <= under_nxt;
      err_oversize <= over_nxt;
      if (eof_nxt) frame_cnt <= frame_cnt + 16'h0001;
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Testbench for eth_tx_framer: random payloads driven through the ready/valid
// port, expected frame bytes built from the frame format rules and queued,
// and a separate monitor comparing every valid output byte against the queue.
module tb_eth_tx_framer;

  localparam int MAXP = 1500;
  localparam int MINP = 46;
  localparam int IFGC = 20;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } exp_t;

  logic        mac_tx_clk = 1'b0;
  logic        mac_tx_reset;
  logic [47:0] cfg_dst_mac, cfg_src_mac;
  logic [15:0] cfg_ethertype;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic [7:0]  mac_tx_data;
  logic        mac_tx_valid, mac_tx_sof, mac_tx_eof, busy;
  logic        err_underrun, err_oversize;
  logic [15:0] frame_cnt;

  exp_t       expQ[$];
  logic [7:0] pay[$];
  int total = 0, bad = 0;
  int expFrames = 0, expUnder = 0, expOver = 0;
  int underSeen = 0, overSeen = 0;
  int gapCnt = 0, lastGap = -1;
  bit inFrame = 0;

  eth_tx_framer #(.MAX_PAYLOAD(MAXP), .MIN_PAYLOAD(MINP), .IFG_CYCLES(IFGC)) dut (
    .mac_tx_clk(mac_tx_clk), .mac_tx_reset(mac_tx_reset),
    .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac), .cfg_ethertype(cfg_ethertype),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .mac_tx_data(mac_tx_data), .mac_tx_valid(mac_tx_valid), .mac_tx_sof(mac_tx_sof),
    .mac_tx_eof(mac_tx_eof), .busy(busy), .err_underrun(err_underrun),
    .err_oversize(err_oversize), .frame_cnt(frame_cnt)
  );

  always #4 mac_tx_clk = ~mac_tx_clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin : watchdog
    #640000;
    $display("[TB] FAIL watchdog: got=running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h want=0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: header, payload (truncated at underrun/oversize), zero pad.
  // cutAt >= 0 means reset hits after that many payload bytes: no eof ever appears.
  function automatic void modelFrame(input logic [47:0] dst, input logic [47:0] src,
                                     input logic [15:0] et, input int underAt, input int cutAt);
    logic [7:0]   bytes[$];
    logic [111:0] h;
    int           keep;
    exp_t         e;
    h = {dst, src, et};
    for (int i = 0; i < 14; i++) bytes.push_back(h[111 - 8*i -: 8]);
    if (cutAt >= 0) begin
      for (int i = 0; i < cutAt; i++) bytes.push_back(pay[i]);
    end else if (underAt >= 0) begin
      for (int i = 0; i < underAt; i++) bytes.push_back(pay[i]);
      bytes.push_back(8'h00);
      expUnder++;
    end else begin
      keep = (pay.size() > MAXP) ? MAXP : pay.size();
      if (pay.size() > MAXP) expOver++;
      for (int i = 0; i < keep; i++) bytes.push_back(pay[i]);
      while (bytes.size() < 14 + MINP) bytes.push_back(8'h00);
    end
    if (cutAt < 0) expFrames++;
    for (int i = 0; i < bytes.size(); i++) begin
      e.data = bytes[i];
      e.sof  = (i == 0);
      e.eof  = (cutAt < 0) && (i == bytes.size() - 1);
      expQ.push_back(e);
    end
  endfunction

  // Drives the payload queue; called and returns at a negedge.
  task automatic applyStimulus(input int underAt, input int cutAt, input bit keepValid,
                               input bit chgType, input logic [15:0] newType);
    bit rdy, acc;
    for (int i = 0; i < pay.size(); i++) begin
      if (i == underAt) begin
        s_tvalid = 1'b0;
        @(negedge mac_tx_clk);
      end
      s_tdata  = pay[i];
      s_tvalid = 1'b1;
      s_tlast  = (i == pay.size() - 1);
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        if (chgType && i == 0 && t == 2) cfg_ethertype = newType;
        rdy = s_tready;
        @(negedge mac_tx_clk);
        acc = rdy;
      end
      checkOutput("accept", {31'd0, acc}, 32'd1);
      if (!acc) begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
      if (i + 1 == cutAt) begin
        mac_tx_reset = 1'b1;
        s_tvalid     = 1'b0;
        s_tlast      = 1'b0;
        return;
      end
    end
    if (!keepValid) begin
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
    end
  endtask

  task automatic waitDrain();
    bit done = 1'b0;
    for (int t = 0; t < 4000 && !done; t++) begin
      @(negedge mac_tx_clk);
      done = (expQ.size() == 0) && (busy === 1'b0);
    end
    checkOutput("drain", {31'd0, done}, 32'd1);
    checkOutput("frame_cnt", {16'd0, frame_cnt}, 32'(expFrames & 16'hFFFF));
    checkOutput("underrun_pulses", underSeen, expUnder);
    checkOutput("oversize_pulses", overSeen, expOver);
  endtask

  task automatic fillRandom(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  // Monitor: pops one expected byte per valid output cycle and tracks gaps.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge mac_tx_clk);
      if (err_underrun === 1'b1) underSeen++;
      if (err_oversize === 1'b1) overSeen++;
      if (mac_tx_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_byte: got=0x%0h want=none", {mac_tx_data, mac_tx_sof, mac_tx_eof});
        end else begin
          e = expQ.pop_front();
          checkOutput("frame_byte", {22'd0, mac_tx_data, mac_tx_sof, mac_tx_eof},
                      {22'd0, e.data, e.sof, e.eof});
        end
        if (mac_tx_sof === 1'b1) begin
          lastGap = gapCnt;
          inFrame = 1'b1;
        end
        if (mac_tx_eof === 1'b1) begin
          inFrame = 1'b0;
          gapCnt  = 0;
        end
      end else begin
        gapCnt++;
        if (inFrame && mac_tx_reset !== 1'b1) begin
          total++;
          bad++;
          $display("[TB] FAIL frame_gap: got=valid0 want=valid1");
        end
      end
      if (mac_tx_reset === 1'b1) inFrame = 1'b0;
    end
  end

  initial begin : stim
    mac_tx_reset  = 1'b1;
    s_tvalid      = 1'b0;
    s_tlast       = 1'b0;
    s_tdata       = 8'h00;
    cfg_dst_mac   = 48'h0200_0000_0001;
    cfg_src_mac   = 48'h000A_3500_0002;
    cfg_ethertype = 16'h0800;
    repeat (3) @(negedge mac_tx_clk);
    checkOutput("rst_data",  {24'd0, mac_tx_data}, 32'd0);
    checkOutput("rst_valid", {31'd0, mac_tx_valid}, 32'd0);
    checkOutput("rst_sof",   {31'd0, mac_tx_sof}, 32'd0);
    checkOutput("rst_eof",   {31'd0, mac_tx_eof}, 32'd0);
    checkOutput("rst_busy",  {31'd0, busy}, 32'd0);
    checkOutput("rst_under", {31'd0, err_underrun}, 32'd0);
    checkOutput("rst_over",  {31'd0, err_oversize}, 32'd0);
    checkOutput("rst_cnt",   {16'd0, frame_cnt}, 32'd0);
    checkOutput("rst_ready", {31'd0, s_tready}, 32'd0);
    mac_tx_reset = 1'b0;
    @(negedge mac_tx_clk);

    $display("[TB] reset asserted at payload byte 30");
    fillRandom(40);
    modelFrame(cfg_dst_mac, cfg_src_mac, cfg_ethertype, -1, 30);
    applyStimulus(-1, 30, 1'b0, 1'b0, 16'h0);
    @(negedge mac_tx_clk);
    checkOutput("abort_valid", {31'd0, mac_tx_valid}, 32'd0);
    checkOutput("abort_eof",   {31'd0, mac_tx_eof}, 32'd0);
    checkOutput("abort_data",  {24'd0, mac_tx_data}, 32'd0);
    checkOutput("abort_busy",  {31'd0, busy}, 32'd0);
    checkOutput("abort_cnt",   {16'd0, frame_cnt}, 32'd0);
    checkOutput("abort_flushed", expQ.size(), 32'd0);
    @(negedge mac_tx_clk);
    mac_tx_reset = 1'b0;
    repeat (2) @(negedge mac_tx_clk);

    $display("[TB] minimum-length pad");
    cfg_dst_mac   = 48'hFFFF_FFFF_FFFF;
    cfg_src_mac   = 48'h000A_3500_0001;
    cfg_ethertype = 16'h0800;
    pay.delete();
    for (int i = 1; i <= 10; i++) pay.push_back(8'(i));
    modelFrame(cfg_dst_mac, cfg_src_mac, cfg_ethertype, -1, -1);
    applyStimulus(-1, -1, 1'b0, 1'b0, 16'h0);
    waitDrain();

    $display("[TB] exact 46-byte and 100-byte payloads");
    fillRandom(46);
    modelFrame(cfg_dst_mac, cfg_src_mac, cfg_ethertype, -1, -1);
    applyStimulus(-1, -1, 1'b0, 1'b0, 16'h0);
    waitDrain();
    fillRandom(100);
    modelFrame(cfg_dst_mac, cfg_src_mac, cfg_ethertype, -1, -1);
    applyStimulus(-1, -1, 1'b0, 1'b0, 16'h0);
    waitDrain();

    $display("[TB] back-to-back frames, EtherType change mid-frame");
    fillRandom(50);
    modelFrame(cfg_dst_mac, cfg_src_mac, cfg_ethertype, -1, -1);
    applyStimulus(-1, -1, 1'b1, 1'b1, 16'h86DD);
    fillRandom(20);
    modelFrame(cfg_dst_mac, cfg_src_mac, 16'h86DD, -1, -1);
    applyStimulus(-1, -1, 1'b0, 1'b0, 16'h0);
    waitDrain();
    checkOutput("ifg_gap", lastGap, IFGC);

    $display("[TB] underrun after payload byte 20");
    fillRandom(40);
    modelFrame(cfg_dst_mac, cfg_src_mac, cfg_ethertype, 20, -1);
    applyStimulus(20, -1, 1'b0, 1'b0, 16'h0);
    waitDrain();

    $display("[TB] oversize 1600-byte payload");
    fillRandom(1600);
    modelFrame(cfg_dst_mac, cfg_src_mac, cfg_ethertype, -1, -1);
    applyStimulus(-1, -1, 1'b0, 1'b0, 16'h0);
    waitDrain();

    $display("[TB] random frames");
    for (int f = 0; f < 8; f++) begin
      cfg_dst_mac   = {16'($urandom), 32'($urandom)};
      cfg_src_mac   = {16'($urandom), 32'($urandom)};
      cfg_ethertype = 16'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge mac_tx_clk);
      fillRandom($urandom_range(1, 200));
      modelFrame(cfg_dst_mac, cfg_src_mac, cfg_ethertype, -1, -1);
      applyStimulus(-1, -1, 1'b0, 1'b0, 16'h0);
      waitDrain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_tx_framer.md
Name: eth_tx_framer

Overview:
- Builds Ethernet II frames for the transmit side of the RGMII MAC.
- Accepts a byte-wide payload stream with a ready/valid handshake and prepends a 14-byte header: destination MAC, source MAC, EtherType.
- Zero-pads the payload to the 46-byte minimum and enforces a configurable inter-frame gap.
- Drives the MAC transmit logic-side interface (data/valid/sof/eof); the MAC adds preamble, SFD and FCS.

Parameters:
- MAX_PAYLOAD, 1500, maximum payload bytes per frame; longer input is truncated.
- MIN_PAYLOAD, 46, payload length below which zero padding is inserted.
- IFG_CYCLES, 20, idle cycles between an eof cycle and the next sof cycle (covers MAC preamble plus the 12-byte IFG). Must be ≥ 2.

Ports:
- mac_tx_clk  in  1  transmit clock (125 MHz gtx clock domain); the only clock.
- mac_tx_reset  in  1  reset, synchronous, active-high.
- cfg_dst_mac  in  48  destination MAC; byte [47:40] is sent first.
- cfg_src_mac  in  48  source MAC; byte [47:40] is sent first.
- cfg_ethertype  in  16  EtherType; byte [15:8] is sent first.
- s_tdata  in  8  payload byte.
- s_tvalid  in  1  payload byte valid.
- s_tlast  in  1  last payload byte of the frame.
- s_tready  out  1  payload byte accepted when s_tvalid & s_tready.
- mac_tx_data  out  8  frame byte to the MAC.
- mac_tx_valid  out  1  mac_tx_data valid.
- mac_tx_sof  out  1  first frame byte (destination MAC byte 0).
- mac_tx_eof  out  1  last frame byte.
- busy  out  1  high in any state other than IDLE.
- err_underrun  out  1  one-cycle pulse: payload starved mid-frame.
- err_oversize  out  1  one-cycle pulse: payload exceeded MAX_PAYLOAD.
- frame_cnt  out  16  frames emitted (including aborted ones); wraps 0xFFFF→0.

Behaviour:
- Single clock domain. Reset is synchronous, active-high.
- All mac_tx_* outputs, err_* outputs and busy are registered. s_tready is decoded directly from the state register.
- Reset values: all outputs 0, frame_cnt 0, state IDLE, byte counters 0.
- Reset asserted mid-frame: outputs are 0 from the next edge, no eof is emitted and frame_cnt is unchanged.
- States: IDLE, HDR, PAYLOAD, PAD, DROP, IFG.
- IDLE: s_tready=0. If s_tvalid=1 at an edge:
  - latch cfg_* (config changes mid-frame are ignored);
  - register header byte 0 with valid=1, sof=1;
  - go to HDR.
- HDR: emits header bytes 1..13 on consecutive cycles with valid=1, no gaps. The edge that registers byte 13 moves the state to PAYLOAD.
- PAYLOAD: s_tready=1. Latency: a byte accepted at edge n appears on mac_tx_data from edge n, i.e. one register stage, with no bubble after the header. Payload count p increments per accepted byte.
  - Accept with s_tlast=1 and p+1 ≥ MIN_PAYLOAD: byte gets eof=1; go to IFG.
  - Accept with s_tlast=1 and p+1 < MIN_PAYLOAD: go to PAD.
  - Accept with s_tlast=0 and p+1 = MAX_PAYLOAD: byte gets eof=1; pulse err_oversize; go to DROP.
  - s_tvalid=0 at an edge: register 0x00 with valid=1, eof=1; pulse err_underrun; go to DROP.
- PAD: s_tready=0. Emits 0x00 until total payload+pad equals MIN_PAYLOAD; the final pad byte carries eof=1. Then go to IFG.
- DROP: mac_tx_valid=0, s_tready=1. Discards bytes until an accepted byte has s_tlast=1, then go to IFG.
- IFG: s_tready=0, valid=0. Counts so that exactly IFG_CYCLES cycles with valid=0 lie between the eof cycle and the next sof cycle, provided s_tvalid is high on exit. Then go to IDLE.
- sof and eof are never asserted together; minimum frame is 60 bytes.
- frame_cnt increments on every cycle with eof=1.

Test Plan:
- Minimum-length pad: dst=FF:FF:FF:FF:FF:FF, src=00:0A:35:00:00:01, type=0x0800, 10-byte payload 0x01..0x0A with last → 60 contiguous valid bytes: 14 header, 0x01..0x0A, then 36×0x00. sof on byte 0, eof on byte 59, frame_cnt=1.
- Exact 46-byte payload → 60 bytes, eof on payload byte 46, PAD not entered. 100-byte payload → 114 bytes.
- Back-to-back frames with s_tvalid held high → exactly 20 cycles with valid=0 between eof and the next sof. cfg_ethertype changed mid-frame is applied only to the second frame.
- Underrun: s_tvalid drops after payload byte 20 → next byte is 0x00 with eof, err_underrun pulses once, remaining input through s_tlast is consumed with no valid output, frame_cnt increments.
- Oversize: 1600-byte payload → eof on payload byte 1500 (frame byte 1514), err_oversize pulses, 100 bytes dropped, then IFG.
- Reset asserted at payload byte 30 → all outputs 0 on the next cycle, no eof, frame_cnt=0. A fresh frame after reset is correct.
